// File: rtl/ir_prefetch_if.sv
// Handshake bundle between instruction memory, the prefetch queue and the control unit.
// "master" is the fetch/control side; "slave" is the queue itself.
interface ir_prefetch_if #(
  parameter int FIELD_W = 4,
  parameter int DEPTH   = 4
) ();
  logic [4*FIELD_W-1:0]      mem_data;
  logic                      mem_valid;
  logic                      mem_ready;
  logic                      ir_advance;
  logic                      flush;
  logic                      ir_valid;
  logic [FIELD_W-1:0]        opcode;
  logic [FIELD_W-1:0]        dest_reg;
  logic [FIELD_W-1:0]        src_reg1;
  logic [FIELD_W-1:0]        src_reg2;
  logic [$clog2(DEPTH):0]    count;

  modport master (
    output mem_data, mem_valid, ir_advance, flush,
    input  mem_ready, ir_valid, opcode, dest_reg, src_reg1, src_reg2, count
  );

  modport slave (
    input  mem_data, mem_valid, ir_advance, flush,
    output mem_ready, ir_valid, opcode, dest_reg, src_reg1, src_reg2, count
  );
endinterface

// File: rtl/ir_prefetch_queue.sv
// Instruction register backed by a DEPTH-entry prefetch FIFO; the head entry is
// presented pre-split into opcode/dest/src fields, or a NOP when empty.
module ir_prefetch_queue #(
  parameter int          FIELD_W      = 4,
  parameter int          DEPTH        = 4,
  parameter int unsigned RESET_OPCODE = 11
) (
  input  logic          clk,
  input  logic          rst,
  ir_prefetch_if.slave  bus
);
  localparam int W  = 4*FIELD_W;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [FIELD_W-1:0] RST_OP = FIELD_W'(RESET_OPCODE);
  localparam logic [CW-1:0]      FULL   = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic          push, pop, ir_valid;
  logic [W-1:0]  head;

  assign ir_valid      = (cnt != '0);
  assign bus.mem_ready = (cnt != FULL) && !bus.flush;
  assign push          = bus.mem_valid && bus.mem_ready;
  assign pop           = bus.ir_advance && ir_valid && !bus.flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.mem_data;
  end

  // Head only depends on registered state, so mem_data never reaches the outputs combinationally.
  assign head         = mem[rd_ptr];
  assign bus.ir_valid = ir_valid;
  assign bus.count    = cnt;
  assign bus.opcode   = ir_valid ? head[4*FIELD_W-1:3*FIELD_W] : RST_OP;
  assign bus.dest_reg = ir_valid ? head[3*FIELD_W-1:2*FIELD_W] : '0;
  assign bus.src_reg1 = ir_valid ? head[2*FIELD_W-1:FIELD_W]   : '0;
  assign bus.src_reg2 = ir_valid ? head[FIELD_W-1:0]           : '0;
endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Directed + randomized bench for ir_prefetch_queue against a queue-based FIFO model.
module tb_ir_prefetch_queue;
  localparam int FIELD_W = 4;
  localparam int DEPTH   = 4;
  localparam int W       = 4*FIELD_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ir_prefetch_if #(.FIELD_W(FIELD_W), .DEPTH(DEPTH)) bus ();

  ir_prefetch_queue #(.FIELD_W(FIELD_W), .DEPTH(DEPTH), .RESET_OPCODE(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] model_q [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every output against what the model predicts for the current inputs.
  task automatic check_outputs(input logic f);
    logic [W-1:0] h;
    bit           v;
    v = (model_q.size() != 0);
    h = v ? model_q[0] : {4'd11, 12'h000};
    chk("mem_ready", 32'(bus.mem_ready), 32'(model_q.size() != DEPTH && !f));
    chk("ir_valid",  32'(bus.ir_valid),  32'(v));
    chk("count",     32'(bus.count),     32'(model_q.size()));
    chk("opcode",    32'(bus.opcode),    32'(h[15:12]));
    chk("dest_reg",  32'(bus.dest_reg),  32'(h[11:8]));
    chk("src_reg1",  32'(bus.src_reg1),  32'(h[7:4]));
    chk("src_reg2",  32'(bus.src_reg2),  32'(h[3:0]));
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic a, input logic f);
    bit do_push, do_pop;
    @(negedge clk);
    bus.mem_valid  = v;
    bus.mem_data   = d;
    bus.ir_advance = a;
    bus.flush      = f;
    #1;
    check_outputs(f);
    if (f) begin
      model_q.delete();
    end else begin
      do_push = v && (model_q.size() < DEPTH);
      do_pop  = a && (model_q.size() > 0);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
    @(posedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    bus.mem_valid = 1'b0; bus.ir_advance = 1'b0; bus.flush = 1'b0;
    model_q.delete();
    #1;
    check_outputs(1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.mem_valid = 1'b0; bus.mem_data = '0; bus.ir_advance = 1'b0; bus.flush = 1'b0;
    #12;
    check_outputs(1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Single push, held until advanced
    step(1, 16'hA123, 0, 0);
    repeat (3) step(0, 16'h0, 0, 0);
    step(0, 16'h0, 1, 0);
    step(0, 16'h0, 0, 0);

    // Fill, 5th word held by source until a pop frees space
    step(1, 16'h1000, 0, 0);
    step(1, 16'h2000, 0, 0);
    step(1, 16'h3000, 0, 0);
    step(1, 16'h4000, 0, 0);
    step(1, 16'h5000, 0, 0);
    step(1, 16'h5000, 0, 0);
    step(1, 16'h5000, 1, 0);
    step(1, 16'h5000, 0, 0);
    repeat (6) step(0, 16'h0, 1, 0);

    // Steady-state push+pop at count 2, pointers wrap
    step(1, 16'h0111, 0, 0);
    step(1, 16'h0222, 0, 0);
    for (int i = 0; i < 10; i++) step(1, W'(16'hB000 + i), 1, 0);
    repeat (3) step(0, 16'h0, 1, 0);

    // Flush with count 3 and a word offered in the flush cycle
    step(1, 16'h1111, 0, 0);
    step(1, 16'h2222, 0, 0);
    step(1, 16'h3333, 0, 0);
    step(1, 16'hDEAD, 0, 1);
    step(1, 16'h7654, 0, 0);
    step(0, 16'h0, 0, 0);

    // Advance while empty, then reset mid-stream with count 2
    step(0, 16'h0, 1, 0);
    step(0, 16'h0, 1, 0);
    step(0, 16'h0, 1, 0);
    step(1, 16'h8888, 0, 0);
    step(1, 16'h9999, 0, 0);
    reset_pulse();
    step(1, 16'hC0DE, 0, 0);
    step(0, 16'h0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) reset_pulse();
      else step(1'($urandom_range(0, 3) != 0), W'($urandom),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
